// File: rtl/spi_regmap_pkg.sv
// Register map, bit positions and frame-buffer fetch encodings shared by the
// SPI register bridge and its frame-buffer fetch engine.
package spi_regmap_pkg;

  // Register window offsets (addr[7:0])
  localparam logic [7:0] REG_ID     = 8'h00;
  localparam logic [7:0] REG_CTRL   = 8'h01;
  localparam logic [7:0] REG_EXP_LO = 8'h02;
  localparam logic [7:0] REG_EXP_HI = 8'h03;
  localparam logic [7:0] REG_GAIN   = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h05;
  localparam logic [7:0] REG_CLR    = 8'h06;

  // Scratch bytes live at 0x10-0x1F (upper nibble selects the page)
  localparam logic [3:0] REG_SCRATCH_PAGE = 4'h1;

  // CTRL bits
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CONT_BIT  = 1;

  // STATUS bits
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_FRDY_BIT = 1;
  localparam int STATUS_ERR_BIT  = 2;

  // CLR (write-one-to-clear) bits
  localparam int CLR_FRDY_BIT = 0;
  localparam int CLR_ERR_BIT  = 1;

  // Byte returned when a frame-buffer read times out
  localparam logic [7:0] FB_ERR_BYTE = 8'hEE;

  // Frame-buffer fetch FSM states
  typedef enum logic [1:0] {
    FB_IDLE = 2'd0,
    FB_REQ  = 2'd1,
    FB_WAIT = 2'd2
  } fb_state_e;

endpackage

// File: rtl/spi_fb_fetch.sv
// Read-request arbiter for the SPI bridge. Every read request passes through
// here: register-window reads are forwarded as a one-cycle pulse, frame-buffer
// reads run a req/valid handshake with timeout. While a frame-buffer fetch is
// in flight one further read is held in a single queue slot; extra reads are
// dropped and flagged as an error.
module spi_fb_fetch
  import spi_regmap_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int FB_ADDR_W  = 20,
  parameter int FB_TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rd_req,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic                 o_reg_rd,
  output logic [7:0]           o_reg_addr,
  output logic                 o_fb_done,
  output logic [7:0]           o_fb_data,
  output logic                 o_err_set,
  output logic                 o_fb_rd_req,
  output logic [FB_ADDR_W-1:0] o_fb_rd_addr,
  input  logic                 i_fb_rd_valid,
  input  logic [7:0]           i_fb_rd_data
);

  localparam int TMO_W = $clog2(FB_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FB_TIMEOUT - 1);

  fb_state_e              r_state;
  fb_state_e              w_state_nxt;
  logic [TMO_W-1:0]       r_tmo;
  logic [FB_ADDR_W-1:0]   r_fb_addr;
  logic                   r_q_vld;
  logic [ADDR_W-1:0]      r_q_addr;
  logic                   r_reg_rd;
  logic [7:0]             r_reg_addr;

  logic                   w_serve;
  logic [ADDR_W-1:0]      w_serve_addr;
  logic                   w_serve_fb;
  logic                   w_q_push;
  logic                   w_q_pop;
  logic                   w_tmo_err;
  logic                   w_q_ovf;
  logic                   w_unused;

  assign w_serve_fb   = w_serve & w_serve_addr[ADDR_W-1];
  assign o_fb_rd_req  = (r_state != FB_IDLE);
  assign o_fb_rd_addr = r_fb_addr;
  assign o_reg_rd     = r_reg_rd;
  assign o_reg_addr   = r_reg_addr;
  assign o_err_set    = w_tmo_err | w_q_ovf;
  assign w_unused     = ^w_serve_addr;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= FB_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state, request dispatch, queue control and completion outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_serve      = 1'b0;
    w_serve_addr = i_rd_addr;
    w_q_push     = 1'b0;
    w_q_pop      = 1'b0;
    w_tmo_err    = 1'b0;
    w_q_ovf      = 1'b0;
    o_fb_done    = 1'b0;
    o_fb_data    = 8'h00;
    case (r_state)
      FB_IDLE: begin
        // A queued read goes first; a read arriving the same cycle takes its slot.
        if (r_q_vld) begin
          w_serve      = 1'b1;
          w_serve_addr = r_q_addr;
          w_q_pop      = 1'b1;
          w_q_push     = i_rd_req;
        end else if (i_rd_req) begin
          w_serve = 1'b1;
        end
        if (w_serve_fb) w_state_nxt = FB_REQ;
      end
      FB_REQ, FB_WAIT: begin
        w_q_push = i_rd_req & ~r_q_vld;
        w_q_ovf  = i_rd_req & r_q_vld;
        if (i_fb_rd_valid) begin
          o_fb_done   = 1'b1;
          o_fb_data   = i_fb_rd_data;
          w_state_nxt = FB_IDLE;
        end else if (r_tmo == TMO_LAST) begin
          o_fb_done   = 1'b1;
          o_fb_data   = FB_ERR_BYTE;
          w_tmo_err   = 1'b1;
          w_state_nxt = FB_IDLE;
        end else begin
          w_state_nxt = FB_WAIT;
        end
      end
      default: w_state_nxt = FB_IDLE;
    endcase
  end

  // Fetch address latch and timeout counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fb_addr <= '0;
      r_tmo     <= '0;
    end else if (w_serve_fb) begin
      r_fb_addr <= w_serve_addr[FB_ADDR_W-1:0];
      r_tmo     <= '0;
    end else if (r_state != FB_IDLE) begin
      r_tmo     <= r_tmo + 1'b1;
    end
  end

  // Single pending-read slot and register-read pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q_vld    <= 1'b0;
      r_q_addr   <= '0;
      r_reg_rd   <= 1'b0;
      r_reg_addr <= 8'h00;
    end else begin
      if (w_q_push) begin
        r_q_vld  <= 1'b1;
        r_q_addr <= i_rd_addr;
      end else if (w_q_pop) begin
        r_q_vld  <= 1'b0;
      end
      r_reg_rd   <= w_serve & ~w_serve_addr[ADDR_W-1];
      r_reg_addr <= w_serve_addr[7:0];
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// Bridge between the SPI memory slave byte bus and camera control logic.
// addr MSB selects the frame-buffer window, otherwise addr[7:0] selects a
// camera register. Optional build macro SPI_BRIDGE_SCRATCH_EN adds 16 RW
// scratch bytes at 0x10-0x1F.
module spi_reg_bridge
  import spi_regmap_pkg::*;
#(
  parameter int         ADDR_BYTES = 3,
  parameter int         FB_ADDR_W  = 20,
  parameter int         FB_TIMEOUT = 16,
  parameter logic [7:0] ID_VALUE   = 8'hA5
) (
  input  logic                    main_clock,
  input  logic                    reset_n,
  input  logic [ADDR_BYTES*8-1:0] addr,
  input  logic [7:0]              write_data,
  input  logic                    write_data_flag,
  output logic [7:0]              read_data,
  input  logic                    read_data_flag,
  output logic [15:0]             exposure,
  output logic [7:0]              gain,
  output logic                    continuous,
  output logic                    start_pulse,
  input  logic                    busy,
  input  logic                    frame_ready,
  output logic                    frame_ready_clr,
  output logic                    fb_rd_req,
  output logic [FB_ADDR_W-1:0]    fb_rd_addr,
  input  logic                    fb_rd_valid,
  input  logic [7:0]              fb_rd_data
);

  localparam int AW = ADDR_BYTES * 8;

  logic        r_wr_flag_d;
  logic        r_rd_flag_d;
  logic [15:0] r_exposure;
  logic [7:0]  r_exp_shadow;
  logic [7:0]  r_exp_hi_snap;
  logic [7:0]  r_gain;
  logic        r_continuous;
  logic        r_start_pulse;
  logic        r_frame_ready_clr;
  logic        r_err;
  logic [7:0]  r_read_data;

  logic        w_wr_rise;
  logic        w_rd_rise;
  logic        w_wr_reg;
  logic [7:0]  w_wr_sel;
  logic        w_reg_rd;
  logic [7:0]  w_reg_addr;
  logic        w_fb_done;
  logic [7:0]  w_fb_data;
  logic        w_err_set;
  logic [7:0]  w_reg_rdata;
  logic [7:0]  w_status;

`ifdef SPI_BRIDGE_SCRATCH_EN
  logic [7:0]  r_scratch [16];
`endif

  assign w_wr_rise = write_data_flag & ~r_wr_flag_d;
  assign w_rd_rise = read_data_flag & ~r_rd_flag_d;
  assign w_wr_reg  = w_wr_rise & ~addr[AW-1];
  assign w_wr_sel  = addr[7:0];

  assign read_data       = r_read_data;
  assign exposure        = r_exposure;
  assign gain            = r_gain;
  assign continuous      = r_continuous;
  assign start_pulse     = r_start_pulse;
  assign frame_ready_clr = r_frame_ready_clr;

  spi_fb_fetch #(
    .ADDR_W     (AW),
    .FB_ADDR_W  (FB_ADDR_W),
    .FB_TIMEOUT (FB_TIMEOUT)
  ) u_fetch (
    .i_clk         (main_clock),
    .i_rst_n       (reset_n),
    .i_rd_req      (w_rd_rise),
    .i_rd_addr     (addr),
    .o_reg_rd      (w_reg_rd),
    .o_reg_addr    (w_reg_addr),
    .o_fb_done     (w_fb_done),
    .o_fb_data     (w_fb_data),
    .o_err_set     (w_err_set),
    .o_fb_rd_req   (fb_rd_req),
    .o_fb_rd_addr  (fb_rd_addr),
    .i_fb_rd_valid (fb_rd_valid),
    .i_fb_rd_data  (fb_rd_data)
  );

  // Keep one registered copy of each flag for rising-edge detection
  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_flag_d <= 1'b0;
      r_rd_flag_d <= 1'b0;
    end else begin
      r_wr_flag_d <= write_data_flag;
      r_rd_flag_d <= read_data_flag;
    end
  end

  // Register writes; start and frame-ready-clear are single-cycle pulses
  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_exposure        <= 16'h0000;
      r_exp_shadow      <= 8'h00;
      r_gain            <= 8'h00;
      r_continuous      <= 1'b0;
      r_start_pulse     <= 1'b0;
      r_frame_ready_clr <= 1'b0;
    end else begin
      r_start_pulse     <= 1'b0;
      r_frame_ready_clr <= 1'b0;
      if (w_wr_reg) begin
        case (w_wr_sel)
          REG_CTRL: begin
            r_start_pulse <= write_data[CTRL_START_BIT];
            r_continuous  <= write_data[CTRL_CONT_BIT];
          end
          REG_EXP_LO: r_exp_shadow      <= write_data;
          REG_EXP_HI: r_exposure        <= {write_data, r_exp_shadow};
          REG_GAIN:   r_gain            <= write_data;
          REG_CLR:    r_frame_ready_clr <= write_data[CLR_FRDY_BIT];
          default: ;
        endcase
      end
    end
  end

  // Sticky error: a new error event wins over a simultaneous clear
  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_wr_reg && w_wr_sel == REG_CLR && write_data[CLR_ERR_BIT]) begin
      r_err <= 1'b0;
    end
  end

`ifdef SPI_BRIDGE_SCRATCH_EN
  // Scratch byte writes
  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) r_scratch[i] <= 8'h00;
    end else if (w_wr_reg && w_wr_sel[7:4] == REG_SCRATCH_PAGE) begin
      r_scratch[w_wr_sel[3:0]] <= write_data;
    end
  end
`endif

  // Register read decode for the forwarded read address
  always_comb begin
    w_status = 8'h00;
    w_status[STATUS_BUSY_BIT] = busy;
    w_status[STATUS_FRDY_BIT] = frame_ready;
    w_status[STATUS_ERR_BIT]  = r_err;
    w_reg_rdata = 8'h00;
    case (w_reg_addr)
      REG_ID:     w_reg_rdata = ID_VALUE;
      REG_CTRL:   w_reg_rdata[CTRL_CONT_BIT] = r_continuous;
      REG_EXP_LO: w_reg_rdata = r_exposure[7:0];
      REG_EXP_HI: w_reg_rdata = r_exp_hi_snap;
      REG_GAIN:   w_reg_rdata = r_gain;
      REG_STATUS: w_reg_rdata = w_status;
      default: begin
`ifdef SPI_BRIDGE_SCRATCH_EN
        if (w_reg_addr[7:4] == REG_SCRATCH_PAGE) w_reg_rdata = r_scratch[w_reg_addr[3:0]];
`else
        if (w_reg_addr[7:4] == REG_SCRATCH_PAGE) w_reg_rdata = 8'h00;
`endif
      end
    endcase
  end

  // read_data update: frame-buffer completion, else register read; EXP_LO
  // reads capture the high byte so a following EXP_HI read is coherent
  always_ff @(posedge main_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_read_data   <= 8'h00;
      r_exp_hi_snap <= 8'h00;
    end else if (w_fb_done) begin
      r_read_data   <= w_fb_data;
    end else if (w_reg_rd) begin
      r_read_data   <= w_reg_rdata;
      if (w_reg_addr == REG_EXP_LO) r_exp_hi_snap <= r_exposure[15:8];
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: expected read bytes are pushed to a
// scoreboard queue when the read is issued and popped when read_data is due.
module tb_spi_reg_bridge;

  logic        main_clock;
  logic        reset_n;
  logic [23:0] addr;
  logic [7:0]  write_data;
  logic        write_data_flag;
  logic [7:0]  read_data;
  logic        read_data_flag;
  logic [15:0] exposure;
  logic [7:0]  gain;
  logic        continuous;
  logic        start_pulse;
  logic        busy;
  logic        frame_ready;
  logic        frame_ready_clr;
  logic        fb_rd_req;
  logic [19:0] fb_rd_addr;
  logic        fb_rd_valid;
  logic [7:0]  fb_rd_data;

  int          total;
  int          bad;
  logic [7:0]  exp_q[$];
  logic [7:0]  expv;

  spi_reg_bridge dut (
    .main_clock      (main_clock),
    .reset_n         (reset_n),
    .addr            (addr),
    .write_data      (write_data),
    .write_data_flag (write_data_flag),
    .read_data       (read_data),
    .read_data_flag  (read_data_flag),
    .exposure        (exposure),
    .gain            (gain),
    .continuous      (continuous),
    .start_pulse     (start_pulse),
    .busy            (busy),
    .frame_ready     (frame_ready),
    .frame_ready_clr (frame_ready_clr),
    .fb_rd_req       (fb_rd_req),
    .fb_rd_addr      (fb_rd_addr),
    .fb_rd_valid     (fb_rd_valid),
    .fb_rd_data      (fb_rd_data)
  );

  initial main_clock = 1'b0;
  always #5 main_clock = ~main_clock;

  // Write one byte: flag held high two cycles, then low one cycle
  task automatic spi_write(input logic [23:0] a, input logic [7:0] d);
    @(posedge main_clock); #1;
    addr = a; write_data = d; write_data_flag = 1'b1;
    @(posedge main_clock); @(posedge main_clock); #1;
    write_data_flag = 1'b0;
    @(posedge main_clock);
  endtask

  // Raise the read flag and return 1 ns after the 2nd edge (read_data due)
  task automatic read_start(input logic [23:0] a);
    @(posedge main_clock); #1;
    addr = a; read_data_flag = 1'b1;
    @(posedge main_clock); @(posedge main_clock); #1;
  endtask

  task automatic read_end();
    read_data_flag = 1'b0;
    @(posedge main_clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge main_clock);
    #1;
    total++; if (read_data !== 8'h00) begin bad++; $display("FAIL reset_read_data got=%h want=00", read_data); end
    total++; if (exposure !== 16'h0000) begin bad++; $display("FAIL reset_exposure got=%h want=0000", exposure); end
    total++; if ({gain, continuous, start_pulse, frame_ready_clr, fb_rd_req} !== 12'h000) begin
      bad++; $display("FAIL reset_ctrl got=%h want=000", {gain, continuous, start_pulse, frame_ready_clr, fb_rd_req});
    end
    total++; if (fb_rd_addr !== 20'h00000) begin bad++; $display("FAIL reset_fb_addr got=%h want=00000", fb_rd_addr); end
    @(negedge main_clock);
    reset_n = 1'b1;
    @(posedge main_clock);
  endtask

  task automatic test_id_status();
    exp_q.push_back(8'hA5);
    read_start(24'h000000);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL id_read got=%h want=%h", read_data, expv); end
    read_end();
    busy = 1'b1; frame_ready = 1'b0;
    exp_q.push_back(8'h01);
    read_start(24'h000005);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL status_busy got=%h want=%h", read_data, expv); end
    read_end();
    busy = 1'b0;
  endtask

  task automatic test_exposure();
    spi_write(24'h000002, 8'h34);
    total++; if (exposure !== 16'h0000) begin bad++; $display("FAIL exp_shadow_only got=%h want=0000", exposure); end
    spi_write(24'h000003, 8'h12);
    total++; if (exposure !== 16'h1234) begin bad++; $display("FAIL exp_commit got=%h want=1234", exposure); end
    exp_q.push_back(8'h34);
    read_start(24'h000002);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL exp_lo_read got=%h want=%h", read_data, expv); end
    read_end();
    exp_q.push_back(8'h12);
    read_start(24'h000003);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL exp_hi_read got=%h want=%h", read_data, expv); end
    read_end();
  endtask

  task automatic test_ctrl();
    int pulses;
    pulses = 0;
    @(posedge main_clock); #1;
    addr = 24'h000001; write_data = 8'h03; write_data_flag = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge main_clock);
      if (start_pulse) pulses++;
    end
    write_data_flag = 1'b0;
    total++; if (pulses !== 1) begin bad++; $display("FAIL start_pulse_len got=%0d want=1", pulses); end
    total++; if (continuous !== 1'b1) begin bad++; $display("FAIL continuous got=%b want=1", continuous); end
    exp_q.push_back(8'h02);
    read_start(24'h000001);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL ctrl_read got=%h want=%h", read_data, expv); end
    read_end();
  endtask

  task automatic test_gain_unmapped();
    spi_write(24'h000004, 8'h5C);
    spi_write(24'h800004, 8'hFF);
    exp_q.push_back(8'h5C);
    read_start(24'h7F0004);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL gain_read got=%h want=%h", read_data, expv); end
    read_end();
    exp_q.push_back(8'h00);
    read_start(24'h000007);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL unmapped_read got=%h want=%h", read_data, expv); end
    read_end();
  endtask

  task automatic test_fb_read();
    bit seen;
    seen = 1'b0;
    @(posedge main_clock); #1;
    addr = 24'h800123; read_data_flag = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge main_clock);
      if (fb_rd_req) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL fb_req_seen got=0 want=1"); end
    total++; if (fb_rd_addr !== 20'h00123) begin bad++; $display("FAIL fb_addr got=%h want=00123", fb_rd_addr); end
    read_data_flag = 1'b0;
    repeat (5) @(posedge main_clock);
    #1;
    fb_rd_valid = 1'b1; fb_rd_data = 8'h5A;
    exp_q.push_back(8'h5A);
    @(posedge main_clock); #1;
    fb_rd_valid = 1'b0; fb_rd_data = 8'h00;
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL fb_data got=%h want=%h", read_data, expv); end
    total++; if (fb_rd_req !== 1'b0) begin bad++; $display("FAIL fb_req_drop got=%b want=0", fb_rd_req); end
    exp_q.push_back(8'h00);
    read_start(24'h000005);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL fb_no_err got=%h want=%h", read_data, expv); end
    read_end();
  endtask

  task automatic test_fb_timeout();
    int hi;
    int pulses;
    hi = 0;
    pulses = 0;
    @(posedge main_clock); #1;
    addr = 24'h800456; read_data_flag = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge main_clock);
      if (fb_rd_req) hi++;
      else if (hi > 0) break;
    end
    total++; if (hi !== 16) begin bad++; $display("FAIL tmo_req_cycles got=%0d want=16", hi); end
    total++; if (read_data !== 8'hEE) begin bad++; $display("FAIL tmo_byte got=%h want=ee", read_data); end
    read_data_flag = 1'b0;
    @(posedge main_clock);
    exp_q.push_back(8'h04);
    read_start(24'h000005);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL tmo_err_status got=%h want=%h", read_data, expv); end
    read_end();
    spi_write(24'h000006, 8'h02);
    exp_q.push_back(8'h00);
    read_start(24'h000005);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL err_clear got=%h want=%h", read_data, expv); end
    read_end();
    @(posedge main_clock); #1;
    addr = 24'h000006; write_data = 8'h01; write_data_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge main_clock);
      if (frame_ready_clr) pulses++;
    end
    write_data_flag = 1'b0;
    total++; if (pulses !== 1) begin bad++; $display("FAIL frdy_clr_pulse got=%0d want=1", pulses); end
  endtask

  // FB fetch busy: one read queued, a further read dropped with err
  task automatic test_back_to_back();
    read_start(24'h800010);
    read_end();
    read_start(24'h000004);
    read_end();
    read_start(24'h000000);
    read_end();
    @(posedge main_clock); #1;
    fb_rd_valid = 1'b1; fb_rd_data = 8'h3C;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h5C);
    @(posedge main_clock); #1;
    fb_rd_valid = 1'b0;
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL q_fb_data got=%h want=%h", read_data, expv); end
    repeat (3) @(posedge main_clock);
    #1;
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL q_served got=%h want=%h", read_data, expv); end
    exp_q.push_back(8'h04);
    read_start(24'h000005);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL q_drop_err got=%h want=%h", read_data, expv); end
    read_end();
    spi_write(24'h000006, 8'h02);
    // write and read rising together: read sees the new value
    @(posedge main_clock); #1;
    addr = 24'h000004; write_data = 8'h99;
    write_data_flag = 1'b1; read_data_flag = 1'b1;
    exp_q.push_back(8'h99);
    repeat (3) @(posedge main_clock);
    #1;
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL wr_rd_same got=%h want=%h", read_data, expv); end
    write_data_flag = 1'b0; read_data_flag = 1'b0;
    @(posedge main_clock);
  endtask

  task automatic test_scratch();
    spi_write(24'h000010, 8'h77);
`ifdef SPI_BRIDGE_SCRATCH_EN
    exp_q.push_back(8'h77);
`else
    exp_q.push_back(8'h00);
`endif
    read_start(24'h000010);
    expv = exp_q.pop_front();
    total++; if (read_data !== expv) begin bad++; $display("FAIL scratch_read got=%h want=%h", read_data, expv); end
    read_end();
  endtask

  task automatic test_reset_mid_fetch();
    bit seen;
    seen = 1'b0;
    @(posedge main_clock); #1;
    addr = 24'h800200; read_data_flag = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge main_clock);
      if (fb_rd_req) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rst_fetch_req got=0 want=1"); end
    @(posedge main_clock); #2;
    reset_n = 1'b0;
    #1;
    total++; if (fb_rd_req !== 1'b0) begin bad++; $display("FAIL rst_async_req got=%b want=0", fb_rd_req); end
    total++; if ({exposure, gain, read_data} !== 32'h0) begin
      bad++; $display("FAIL rst_state got=%h want=00000000", {exposure, gain, read_data});
    end
    read_data_flag = 1'b0;
    @(negedge main_clock);
    reset_n = 1'b1;
    repeat (2) @(posedge main_clock);
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0; addr = '0; write_data = '0; write_data_flag = 1'b0;
    read_data_flag = 1'b0; busy = 1'b0; frame_ready = 1'b0;
    fb_rd_valid = 1'b0; fb_rd_data = '0;
    test_reset();
    test_id_status();
    test_exposure();
    test_ctrl();
    test_gain_unmapped();
    test_fb_read();
    test_fb_timeout();
    test_back_to_back();
    test_scratch();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
